// File: rtl/multicycle_control.sv
// Main multi-cycle control FSM of the 16-bit core. It sequences fetch, decode,
// execute, memory and writeback, and runs a memory-wait watchdog.
// Ports:
//   clk, reset (async, active-low)
//   op[3:0]           opcode from IR
//   zero              ALU zero flag (used in BRANCH)
//   mem_ready         memory completes the current access this cycle
//   mem_read/mem_write/iord/ir_write/pc_write   datapath strobes
//   pc_src[1:0], alu_src_a, alu_src_b[1:0]      datapath mux selects
//   reg_write, reg_dst[1:0], mem_to_reg[1:0]    register file controls
//   state[3:0]        current state (debug)
//   halted, fault     core stopped / watchdog expired
module multicycle_control #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [3:0] state,
  output logic       halted,
  output logic       fault
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [3:0] {
    S_START    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_BRANCH   = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12,
    S_FAULT    = 4'd13
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Remembers whether the ALU writeback targets rd (R-type) or rt (I-type)
  logic             rdst_q, rdst_d;

  // State, watchdog counter and writeback-destination registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_START;
      cnt_q   <= '0;
      rdst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdst_q  <= rdst_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    rdst_d     = rdst_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    halted     = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        case (op)
          4'b0000:                   state_d = S_EXEC_R;
          4'b0010, 4'b0011:          state_d = S_BRANCH;
          4'b0100, 4'b0101:          state_d = S_MEM_ADDR;
          4'b0110, 4'b0111, 4'b1110: state_d = S_JUMP;
          4'b1111:                   state_d = S_HALT;
          default:                   state_d = S_EXEC_I; // 0001, 1000-1101
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        reg_dst   = 2'd1;
        rdst_d    = 1'b1;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        rdst_d    = 1'b0;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = {1'b0, rdst_q};
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = 2'd1;
        // op[0] distinguishes bne from beq
        pc_write  = op[0] ? ~zero : zero;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = op[0] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = (op == 4'b1110) ? 2'd3 : 2'd2;
        if (op == 4'b0111) begin
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
        state_d = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      S_FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
      default: state_d = S_START;
    endcase

    // Watchdog: count stalled memory cycles; the WAIT_MAX-th one faults
    if ((state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR) && !mem_ready) begin
      if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
        state_d = S_FAULT;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level generator
// expands each instruction into its expected per-cycle state/output trace.
module tb_multicycle_control;

  localparam int unsigned WM = 4;

  logic       clk, reset, zero, mem_ready;
  logic [3:0] op;
  logic       mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic       alu_src_a, reg_write, halted, fault;
  logic [3:0] state;

  multicycle_control #(.WAIT_MAX(WM)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
    .halted(halted), .fault(fault)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mr, mw, io, irw, pcw;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic       rw;
    logic [1:0] rd, m2r;
    logic       hl, ft;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  bit   faulted;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle spent in state st with the given inputs
  function automatic exp_t outs(int st, logic [3:0] o, logic z, logic rdy);
    exp_t e = '0;
    e.st = 4'(st);
    case (st)
      1:  begin e.mr = 1; e.asb = 2'd1; e.irw = rdy; e.pcw = rdy; end
      2:  e.asb = 2'd3;
      3:  begin e.asa = 1; e.rd = 2'd1; end
      4:  begin e.asa = 1; e.asb = 2'd2; end
      5:  begin e.rw = 1; e.rd = (o == 4'd0) ? 2'd1 : 2'd0; end
      6:  begin e.asa = 1; e.pcs = 2'd1; e.pcw = (o == 4'd2) ? z : ~z; end
      7:  begin e.asa = 1; e.asb = 2'd2; end
      8:  begin e.mr = 1; e.io = 1; end
      9:  begin e.rw = 1; e.m2r = 2'd1; end
      10: begin e.mw = 1; e.io = 1; end
      11: begin
        e.pcw = 1;
        e.pcs = (o == 4'd14) ? 2'd3 : 2'd2;
        if (o == 4'd7) begin e.rw = 1; e.rd = 2'd2; e.m2r = 2'd2; end
      end
      12: e.hl = 1;
      13: begin e.hl = 1; e.ft = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic pickz(int zf);
    return (zf == 2) ? 1'($urandom) : 1'(zf);
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during it
  task automatic cyc(logic rst, logic [3:0] o, logic z, logic rdy, int st);
    reset = rst; op = o; zero = z; mem_ready = rdy;
    exp_q.push_back(rst ? outs(st, o, z, rdy) : outs(0, o, z, rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), 0);
    cyc(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 0);
  endtask

  // A memory-waiting state: 'waits' stalled cycles, then ready (or fault at WM)
  task automatic wait_state(int st, logic [3:0] o, int waits, int zf);
    int n;
    n = (waits < int'(WM)) ? waits : int'(WM);
    for (int i = 0; i < n; i++) cyc(1'b1, o, pickz(zf), 1'b0, st);
    if (waits >= int'(WM)) faulted = 1;
    else cyc(1'b1, o, pickz(zf), 1'b1, st);
  endtask

  task automatic run_instr(logic [3:0] o, int fw, int mw, int zf);
    faulted = 0;
    wait_state(1, o, fw, zf);
    if (!faulted) begin
      cyc(1'b1, o, pickz(zf), 1'($urandom), 2);
      case (o)
        4'd0: begin
          cyc(1'b1, o, pickz(zf), 1'($urandom), 3);
          cyc(1'b1, o, pickz(zf), 1'($urandom), 5);
        end
        4'd2, 4'd3: cyc(1'b1, o, pickz(zf), 1'($urandom), 6);
        4'd4: begin
          cyc(1'b1, o, pickz(zf), 1'($urandom), 7);
          wait_state(8, o, mw, zf);
          if (!faulted) cyc(1'b1, o, pickz(zf), 1'($urandom), 9);
        end
        4'd5: begin
          cyc(1'b1, o, pickz(zf), 1'($urandom), 7);
          wait_state(10, o, mw, zf);
        end
        4'd6, 4'd7, 4'd14: cyc(1'b1, o, pickz(zf), 1'($urandom), 11);
        4'd15: begin
          for (int i = 0; i < 20; i++) cyc(1'b1, o, pickz(zf), 1'($urandom), 12);
          do_reset();
        end
        default: begin
          cyc(1'b1, o, pickz(zf), 1'($urandom), 4);
          cyc(1'b1, o, pickz(zf), 1'($urandom), 5);
        end
      endcase
    end
    if (faulted) begin
      for (int i = 0; i < 5; i++) cyc(1'b1, o, pickz(zf), 1'($urandom), 13);
      do_reset();
    end
  endtask

  // Monitor: compare every sampled cycle against the scoreboard head
  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.st = state; a.mr = mem_read; a.mw = mem_write; a.io = iord;
      a.irw = ir_write; a.pcw = pc_write; a.pcs = pc_src; a.asa = alu_src_a;
      a.asb = alu_src_b; a.rw = reg_write; a.rd = reg_dst; a.m2r = mem_to_reg;
      a.hl = halted; a.ft = fault;
      vectors++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl_outputs t=%0t state got %0d exp %0d, fields got %h exp %h",
                 $time, a.st, e.st, a, e);
      end
    end
  end

  initial begin
    int fw, mw;
    logic [3:0] o;
    reset = 1'b0; op = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    // Directed: R-type, branches, lw with waits, boundary waits, jumps
    run_instr(4'd0, 0, 0, 2);
    run_instr(4'd2, 0, 0, 1);
    run_instr(4'd2, 0, 0, 0);
    run_instr(4'd3, 0, 0, 1);
    run_instr(4'd3, 0, 0, 0);
    run_instr(4'd4, 0, 3, 2);
    run_instr(4'd5, int'(WM) - 1, int'(WM) - 1, 2);
    run_instr(4'd4, int'(WM) - 1, int'(WM) - 1, 2);
    run_instr(4'd7, 0, 0, 2);
    run_instr(4'd6, 1, 0, 2);
    run_instr(4'd14, 2, 0, 2);
    run_instr(4'd9, 0, 0, 2);
    // Watchdog faults in FETCH, MEM_RD and MEM_WR
    run_instr(4'd0, int'(WM), 0, 2);
    run_instr(4'd4, 0, int'(WM), 2);
    run_instr(4'd5, 0, int'(WM) + 1, 2);
    // Halt, then reset mid-instruction during a stalled read
    run_instr(4'd15, 0, 0, 2);
    cyc(1'b1, 4'd4, 1'b0, 1'b1, 1);
    cyc(1'b1, 4'd4, 1'b0, 1'b0, 2);
    cyc(1'b1, 4'd4, 1'b0, 1'b0, 7);
    cyc(1'b1, 4'd4, 1'b0, 1'b0, 8);
    do_reset();
    // Random instruction stream
    for (int k = 0; k < 150; k++) begin
      o  = 4'($urandom);
      fw = ($urandom_range(0, 19) == 0) ? int'(WM) + int'($urandom_range(0, 2))
                                        : int'($urandom_range(0, WM - 1));
      mw = ($urandom_range(0, 19) == 0) ? int'(WM) + int'($urandom_range(0, 2))
                                        : int'($urandom_range(0, WM - 1));
      run_instr(o, fw, mw, 2);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
